mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset: clk in, rst in, reset sampled on the rising edge of clk.
REQ-002 Parameters SHALL be: MEM_LATENCY, default 1, cycles from address presented to data_from_memory valid, minimum 1; STARVE_LIMIT, default 4, consecutive MA grants tolerated while IF waits.
REQ-003 clk  in  1  core clock.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 if_req  in  1  fetch read request; held with if_addr stable until if_gnt.
REQ-006 if_addr  in  16  fetch address.
REQ-007 if_gnt  out  1  one-cycle grant pulse to fetch.
REQ-008 if_rvalid  out  1  one-cycle fetch read-data valid.
REQ-009 if_rdata  out  16  fetch read data; holds until the next fetch rvalid.
REQ-010 ma_req, ma_we  in  1 each  memory-stage request and write flag; held with address and data stable until ma_gnt.
REQ-011 ma_addr, ma_wdata  in  16 each  memory-stage address and write data.
REQ-012 ma_gnt, ma_rvalid  out  1 each; ma_rdata  out  16; same semantics as the fetch-side signals.
REQ-013 to_mem_addr, core_to_mem_data  out  16; core_to_mem_write_enable  out  1; data_from_memory  in  16: the single memory port.
REQ-014 busy  out  1  high whenever the state is not IDLE.

Function
REQ-015 The FSM SHALL have the states IDLE and BUSY, and a latency counter sized for MEM_LATENCY+1.
REQ-016 In IDLE at cycle T with any request pending, the block SHALL pick a winner, register the port outputs, and enter BUSY at T+1.
REQ-017 At T+1 the block SHALL drive the winner's address and data on the port, pulse the winner's gnt, and assert write enable for that cycle only, and only if the winner is MA with ma_we=1.
REQ-018 At T+1+MEM_LATENCY the block SHALL capture data_from_memory into the winner's rdata register for reads.
REQ-019 At T+2+MEM_LATENCY the block SHALL return to IDLE, pulse the winner's rvalid for reads (none for writes), and may sample a new request in that same cycle.
REQ-020 Throughput SHALL be one access per MEM_LATENCY+2 cycles, with no overlap of accesses.
REQ-021 Simultaneous if_req and ma_req SHALL grant MA, except as overridden by REQ-027.
REQ-022 Requests asserted while BUSY SHALL be ignored until IDLE, with no loss provided the requester holds its req.
REQ-023 Between grants, to_mem_addr and core_to_mem_data SHALL hold their last values, and write enable SHALL be 0.
REQ-024 At most one gnt and one rvalid SHALL be high in any cycle.

Reset
REQ-025 Reset SHALL set state IDLE, counter 0, all gnt/rvalid/busy/write-enable 0, to_mem_addr 0, core_to_mem_data 0, and if_rdata/ma_rdata 0.
REQ-026 Reset during BUSY SHALL abort the access: no rvalid for it, with IDLE and arbitration resuming on the first cycle after rst falls.

Configuration
REQ-027 With MEM_ARB_STARVE_GUARD_EN defined, a counter SHALL track consecutive MA grants made while if_req was high; once it reaches STARVE_LIMIT, the next arbitration SHALL grant IF, and the counter SHALL clear on any IF grant or whenever if_req is low in IDLE.
REQ-028 Without MEM_ARB_STARVE_GUARD_EN, strict MA priority SHALL apply and no starvation counter SHALL exist.

Structure
REQ-029 Shared package core_pkg SHALL hold the 16-bit word typedef, the arbiter state enum (IDLE, BUSY), and the default MEM_LATENCY and STARVE_LIMIT constants.
REQ-030 Sub-module mem_arb_latency_counter SHALL implement load-and-count-down and a done flag; arbitration and the FSM SHALL stay in mem_port_arbiter.

Verification
REQ-031 MEM_LATENCY=1; if_req with if_addr=0x0010 at cycle 0; memory returns 0xBEEF at cycle 2 -> if_gnt at cycle 1, if_rvalid at cycle 3, if_rdata=0xBEEF.
REQ-032 if_req and ma_req together, ma_we=1, ma_addr=0x0200, ma_wdata=0x1234 -> ma_gnt and write enable at cycle 1 with port 0x0200/0x1234, no ma_rvalid; if_gnt at cycle 4.
REQ-033 MEM_LATENCY=3; MA read of 0x0040, memory returns 0x00AA at cycle 4 -> ma_rvalid at cycle 5, busy high for cycles 1 to 4.
REQ-034 rst pulsed at cycle 2 of an IF read -> no if_rvalid, all outputs at reset values, and a new request after rst is granted normally.
REQ-035 Guard defined, STARVE_LIMIT=4, ma_req and if_req held high -> four MA grants then one IF grant, repeating; guard undefined -> no IF grant while ma_req is high.

Source files
------------

// File: rtl/core_pkg.sv
// Shared types and default constants for the memory port arbiter.
package core_pkg;

  typedef logic [15:0] word_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  localparam int DEFAULT_MEM_LATENCY  = 1;
  localparam int DEFAULT_STARVE_LIMIT = 4;

endpackage

// File: rtl/mem_arb_latency_counter.sv
// Load-and-count-down timer; done is high whenever the count has reached zero.
module mem_arb_latency_counter #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             done
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_value;
    end else if (count_q != '0) begin
      count_q <= count_q - WIDTH'(1);
    end
  end

  assign done = (count_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester (fetch / memory-stage) arbiter for a single memory port.
// Optional starvation guard for fetch: define MEM_ARB_STARVE_GUARD_EN.
module mem_port_arbiter
  import core_pkg::*;
#(
  parameter int MEM_LATENCY  = DEFAULT_MEM_LATENCY,
  parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [15:0] if_rdata,
  input  logic        ma_req,
  input  logic        ma_we,
  input  logic [15:0] ma_addr,
  input  logic [15:0] ma_wdata,
  output logic        ma_gnt,
  output logic        ma_rvalid,
  output logic [15:0] ma_rdata,
  output logic [15:0] to_mem_addr,
  output logic [15:0] core_to_mem_data,
  output logic        core_to_mem_write_enable,
  input  logic [15:0] data_from_memory,
  output logic        busy
);

  localparam int CNT_W = (MEM_LATENCY < 1) ? 1 : $clog2(MEM_LATENCY + 1);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MEM_LATENCY);

  generate
    if (MEM_LATENCY < 1 || STARVE_LIMIT < 1) begin : g_param_check
      $error("mem_port_arbiter: MEM_LATENCY and STARVE_LIMIT must be at least 1");
    end
  endgenerate

  arb_state_t state_q, state_d;
  logic       start, finish, pick_ma, force_if, cnt_done;
  logic       sel_ma_q, is_write_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    finish  = 1'b0;
    pick_ma = 1'b0;
    case (state_q)
      IDLE: begin
        if (if_req || ma_req) begin
          start   = 1'b1;
          pick_ma = ma_req && !force_if;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_done) begin
          finish  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Counter is loaded at the grant edge, so it reads zero in the capture cycle.
  mem_arb_latency_counter #(.WIDTH(CNT_W)) u_latency (
    .clk        (clk),
    .rst        (rst),
    .load       (start),
    .load_value (LOAD_VAL),
    .done       (cnt_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      if_gnt                   <= 1'b0;
      ma_gnt                   <= 1'b0;
      if_rvalid                <= 1'b0;
      ma_rvalid                <= 1'b0;
      core_to_mem_write_enable <= 1'b0;
      to_mem_addr              <= '0;
      core_to_mem_data         <= '0;
      if_rdata                 <= '0;
      ma_rdata                 <= '0;
      sel_ma_q                 <= 1'b0;
      is_write_q               <= 1'b0;
    end else begin
      if_gnt                   <= 1'b0;
      ma_gnt                   <= 1'b0;
      if_rvalid                <= 1'b0;
      ma_rvalid                <= 1'b0;
      core_to_mem_write_enable <= 1'b0;
      if (start) begin
        if_gnt                   <= !pick_ma;
        ma_gnt                   <= pick_ma;
        to_mem_addr              <= pick_ma ? ma_addr : if_addr;
        core_to_mem_write_enable <= pick_ma && ma_we;
        sel_ma_q                 <= pick_ma;
        is_write_q               <= pick_ma && ma_we;
        if (pick_ma) core_to_mem_data <= ma_wdata;
      end
      // Fetch has no write data, so the port keeps the last store value.
      if (finish && !is_write_q) begin
        if (sel_ma_q) begin
          ma_rdata  <= data_from_memory;
          ma_rvalid <= 1'b1;
        end else begin
          if_rdata  <= data_from_memory;
          if_rvalid <= 1'b1;
        end
      end
    end
  end

  assign busy = (state_q != IDLE);

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
  logic [STARVE_W-1:0] starve_q;

  // Saturating count of MA wins while fetch was left waiting.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= '0;
    end else if (state_q == IDLE) begin
      if (!if_req || (start && !pick_ma)) begin
        starve_q <= '0;
      end else if (start && pick_ma && starve_q != STARVE_W'(STARVE_LIMIT)) begin
        starve_q <= starve_q + STARVE_W'(1);
      end
    end
  end

  assign force_if = if_req && (starve_q == STARVE_W'(STARVE_LIMIT));
`else
  assign force_if = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: directed scenarios plus a randomized run against a
// transaction-level schedule model of the arbiter.
module tb_mem_port_arbiter;
  import core_pkg::*;

  localparam int LAT   = 3;
  localparam int LIMIT = 4;
`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, ma_req, ma_we;
  logic [15:0] if_addr, ma_addr, ma_wdata, data_from_memory;
  logic        if_gnt, if_rvalid, ma_gnt, ma_rvalid, busy, core_to_mem_write_enable;
  logic [15:0] if_rdata, ma_rdata, to_mem_addr, core_to_mem_data;

  int errors = 0;
  int checks = 0;

  mem_port_arbiter #(.MEM_LATENCY(LAT), .STARVE_LIMIT(LIMIT)) dut (
    .clk                      (clk),
    .rst                      (rst),
    .if_req                   (if_req),
    .if_addr                  (if_addr),
    .if_gnt                   (if_gnt),
    .if_rvalid                (if_rvalid),
    .if_rdata                 (if_rdata),
    .ma_req                   (ma_req),
    .ma_we                    (ma_we),
    .ma_addr                  (ma_addr),
    .ma_wdata                 (ma_wdata),
    .ma_gnt                   (ma_gnt),
    .ma_rvalid                (ma_rvalid),
    .ma_rdata                 (ma_rdata),
    .to_mem_addr              (to_mem_addr),
    .core_to_mem_data         (core_to_mem_data),
    .core_to_mem_write_enable (core_to_mem_write_enable),
    .data_from_memory         (data_from_memory),
    .busy                     (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [69:0] out_vec();
    return {if_gnt, ma_gnt, if_rvalid, ma_rvalid, busy, core_to_mem_write_enable,
            to_mem_addr, core_to_mem_data, if_rdata, ma_rdata};
  endfunction

  task automatic applyStimulus(input logic ireq, input logic [15:0] iaddr, input logic mreq,
                               input logic mwe, input logic [15:0] maddr, input logic [15:0] mwdata);
    if_req   = ireq;
    if_addr  = iaddr;
    ma_req   = mreq;
    ma_we    = mwe;
    ma_addr  = maddr;
    ma_wdata = mwdata;
  endtask

  // Leaves the bench at the negedge of the first cycle with rst low.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    data_from_memory = 16'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
    data_from_memory = 16'h0;
    repeat (3) @(negedge clk);
    checks++;
    if (out_vec() !== 70'h0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %h expected 0", out_vec());
    end
    rst = 1'b0;
  endtask

  task automatic test_if_read();
    @(negedge clk);
    applyStimulus(1'b1, 16'h0010, 1'b0, 1'b0, 16'h0, 16'h0);
    for (int c = 1; c <= LAT + 2; c++) begin
      @(negedge clk);
      checks++;
      if (if_gnt !== (c == 1)) begin
        errors++; $display("[TB] FAIL if_read_gnt c=%0d: got %b expected %b", c, if_gnt, c == 1);
      end
      checks++;
      if (if_rvalid !== (c == LAT + 2)) begin
        errors++; $display("[TB] FAIL if_read_rvalid c=%0d: got %b expected %b", c, if_rvalid, c == LAT + 2);
      end
      if (c == 1) begin
        checks++;
        if (to_mem_addr !== 16'h0010 || core_to_mem_write_enable !== 1'b0) begin
          errors++; $display("[TB] FAIL if_read_port: got addr %h we %b expected 0010 0", to_mem_addr, core_to_mem_write_enable);
        end
        if_req = 1'b0;
      end
      data_from_memory = (c == LAT + 1) ? 16'hBEEF : 16'hDEAD;
    end
    checks++;
    if (if_rdata !== 16'hBEEF) begin
      errors++; $display("[TB] FAIL if_read_data: got %h expected beef", if_rdata);
    end
  endtask

  task automatic test_write_priority();
    @(negedge clk);
    applyStimulus(1'b1, 16'h0020, 1'b1, 1'b1, 16'h0200, 16'h1234);
    for (int c = 1; c <= 2 * LAT + 4; c++) begin
      @(negedge clk);
      checks++;
      if (ma_gnt !== (c == 1) || core_to_mem_write_enable !== (c == 1)) begin
        errors++; $display("[TB] FAIL wr_gnt_we c=%0d: got gnt %b we %b expected %b", c, ma_gnt, core_to_mem_write_enable, c == 1);
      end
      checks++;
      if (ma_rvalid !== 1'b0) begin
        errors++; $display("[TB] FAIL wr_no_rvalid c=%0d: got %b expected 0", c, ma_rvalid);
      end
      checks++;
      if (if_gnt !== (c == LAT + 3)) begin
        errors++; $display("[TB] FAIL wr_if_gnt c=%0d: got %b expected %b", c, if_gnt, c == LAT + 3);
      end
      checks++;
      if (if_rvalid !== (c == 2 * LAT + 4)) begin
        errors++; $display("[TB] FAIL wr_if_rvalid c=%0d: got %b expected %b", c, if_rvalid, c == 2 * LAT + 4);
      end
      if (c <= LAT + 2) begin
        checks++;
        if (to_mem_addr !== 16'h0200 || core_to_mem_data !== 16'h1234) begin
          errors++; $display("[TB] FAIL wr_port c=%0d: got %h/%h expected 0200/1234", c, to_mem_addr, core_to_mem_data);
        end
      end
      if (c == 1) ma_req = 1'b0;
      if (c == LAT + 3) if_req = 1'b0;
      data_from_memory = 16'h0F0F;
    end
  endtask

  task automatic test_ma_read_busy();
    @(negedge clk);
    applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 16'h0040, 16'h0);
    data_from_memory = 16'h5555;
    for (int c = 0; c <= LAT + 2; c++) begin
      if (c > 0) @(negedge clk);
      checks++;
      if (busy !== (c >= 1 && c <= LAT + 1)) begin
        errors++; $display("[TB] FAIL ma_busy c=%0d: got %b expected %b", c, busy, c >= 1 && c <= LAT + 1);
      end
      checks++;
      if (ma_rvalid !== (c == LAT + 2) || if_rvalid !== 1'b0) begin
        errors++; $display("[TB] FAIL ma_rvalid c=%0d: got %b/%b expected %b/0", c, ma_rvalid, if_rvalid, c == LAT + 2);
      end
      if (c == 1) ma_req = 1'b0;
      data_from_memory = (c == LAT + 1) ? 16'h00AA : 16'h5555;
    end
    checks++;
    if (ma_rdata !== 16'h00AA) begin
      errors++; $display("[TB] FAIL ma_read_data: got %h expected 00aa", ma_rdata);
    end
  endtask

  task automatic test_reset_abort();
    @(negedge clk);
    applyStimulus(1'b1, 16'h0300, 1'b0, 1'b0, 16'h0, 16'h0);
    data_from_memory = 16'h1111;
    @(negedge clk);
    if_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (out_vec() !== 70'h0) begin
      errors++; $display("[TB] FAIL abort_reset_outputs: got %h expected 0", out_vec());
    end
    rst = 1'b0;
    applyStimulus(1'b1, 16'h0044, 1'b0, 1'b0, 16'h0, 16'h0);
    for (int c = 4; c <= LAT + 5; c++) begin
      @(negedge clk);
      checks++;
      if (if_gnt !== (c == 4)) begin
        errors++; $display("[TB] FAIL abort_regrant c=%0d: got %b expected %b", c, if_gnt, c == 4);
      end
      checks++;
      if (if_rvalid !== (c == LAT + 5)) begin
        errors++; $display("[TB] FAIL abort_rvalid c=%0d: got %b expected %b", c, if_rvalid, c == LAT + 5);
      end
      if (c == 4) if_req = 1'b0;
      data_from_memory = (c == LAT + 4) ? 16'h5A5A : 16'h1111;
    end
    checks++;
    if (if_rdata !== 16'h5A5A) begin
      errors++; $display("[TB] FAIL abort_new_data: got %h expected 5a5a", if_rdata);
    end
  endtask

  task automatic test_starvation();
    int n = 0;
    int last = 0;
    do_reset();
    applyStimulus(1'b1, 16'h0100, 1'b1, 1'b0, 16'h0300, 16'h0);
    for (int c = 1; c <= 12 * (LAT + 2) + 10 && n < 10; c++) begin
      @(negedge clk);
      if (if_gnt || ma_gnt) begin
        logic exp_if;
        exp_if = GUARD && (n % (LIMIT + 1) == LIMIT);
        checks++;
        if (if_gnt !== exp_if || ma_gnt !== !exp_if) begin
          errors++; $display("[TB] FAIL starve_winner grant=%0d: got if %b ma %b expected if %b", n, if_gnt, ma_gnt, exp_if);
        end
        checks++;
        if (c - last != ((n == 0) ? 1 : LAT + 2)) begin
          errors++; $display("[TB] FAIL starve_spacing grant=%0d: got %0d cycles expected %0d", n, c - last, (n == 0) ? 1 : LAT + 2);
        end
        last = c;
        n++;
      end
    end
    checks++;
    if (n < 10) begin
      errors++; $display("[TB] FAIL starve_timeout: got %0d grants expected 10", n);
    end
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  // Model: one access at a time; decision at c grants at c+1, captures at
  // c+1+LAT, reports at c+2+LAT, which is also the next decision slot.
  task automatic test_random();
    int          free_at = 0, g = 0, starve = 0;
    bit          act = 0, w_ma = 0, w_we = 0, if_pend = 0, ma_pend = 0;
    logic [15:0] cap = 0, t_addr = 0, t_data = 0;
    logic [15:0] e_addr = 0, e_data = 0, e_if_rd = 0, e_ma_rd = 0;
    logic        e_ig, e_mg, e_we, e_busy, e_irv, e_mrv;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if (c > 0) @(negedge clk);
      e_ig   = act && c == g && !w_ma;
      e_mg   = act && c == g && w_ma;
      e_we   = act && c == g && w_ma && w_we;
      e_busy = act && c >= g && c <= g + LAT;
      e_irv  = act && c == g + LAT + 1 && !w_we && !w_ma;
      e_mrv  = act && c == g + LAT + 1 && !w_we && w_ma;
      if (act && c == g) begin
        e_addr = t_addr;
        if (w_ma) e_data = t_data;
      end
      if (e_irv) e_if_rd = cap;
      if (e_mrv) e_ma_rd = cap;
      checks++;
      if ({if_gnt, ma_gnt, core_to_mem_write_enable, busy, if_rvalid, ma_rvalid} !==
          {e_ig, e_mg, e_we, e_busy, e_irv, e_mrv}) begin
        errors++;
        $display("[TB] FAIL rand_ctrl c=%0d: got %b%b%b%b%b%b expected %b%b%b%b%b%b", c,
                 if_gnt, ma_gnt, core_to_mem_write_enable, busy, if_rvalid, ma_rvalid,
                 e_ig, e_mg, e_we, e_busy, e_irv, e_mrv);
      end
      checks++;
      if ({to_mem_addr, core_to_mem_data, if_rdata, ma_rdata} !== {e_addr, e_data, e_if_rd, e_ma_rd}) begin
        errors++;
        $display("[TB] FAIL rand_data c=%0d: got %h %h %h %h expected %h %h %h %h", c,
                 to_mem_addr, core_to_mem_data, if_rdata, ma_rdata, e_addr, e_data, e_if_rd, e_ma_rd);
      end
      if (act && c == g + LAT + 1) act = 0;
      data_from_memory = 16'($urandom);
      if (act && c == g + LAT) cap = data_from_memory;
      if (!if_pend) begin
        if_addr = 16'($urandom);
        if ($urandom_range(0, 3) == 0) if_pend = 1;
      end
      if (!ma_pend) begin
        ma_addr  = 16'($urandom);
        ma_wdata = 16'($urandom);
        ma_we    = 1'($urandom);
        if ($urandom_range(0, 2) == 0) ma_pend = 1;
      end
      if_req = if_pend;
      ma_req = ma_pend;
      if (c >= free_at) begin
        if (!if_req) starve = 0;
        if (if_req || ma_req) begin
          w_ma = ma_req && !(GUARD && if_req && starve >= LIMIT);
          if (w_ma) begin
            if (if_req) starve++;
            ma_pend = 0; w_we = ma_we; t_addr = ma_addr; t_data = ma_wdata;
          end else begin
            starve = 0; if_pend = 0; w_we = 0; t_addr = if_addr;
          end
          act = 1; g = c + 1; free_at = c + LAT + 2;
        end
      end
    end
    applyStimulus(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  initial begin
    test_reset();
    test_if_read();
    test_write_priority();
    test_ma_read_busy();
    test_reset_abort();
    test_starvation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
